rename_rob: RTL and testbench
=============================

RENAME_ROB -- requirements
Module: rename_rob

Interface
REQ-001 SHALL have parameter DATA_W, default 16, architectural data width.
REQ-002 SHALL have parameter TAG_W, default 6, ROB tag width; depth = 2**TAG_W = 64 entries.
REQ-003 SHALL have clk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have flush, input, 1, external pipeline flush.
REQ-006 SHALL have alloc_cnt, input, 3, entries to allocate this cycle (0..4), in slot order 0..3.
REQ-007 SHALL have alloc_wreg0..3, input, 1 each, slot writes an architectural register.
REQ-008 SHALL have alloc_waddr0..3, input, 3 each, destination register per slot.
REQ-009 SHALL have alloc_tag0..3, output, TAG_W each, combinational tail+i mod 64, driven to register-file rename ports.
REQ-010 SHALL have alloc_ready, output, 1, combinational, free entries >= 4.
REQ-011 SHALL have cmp_valid0..2, input, 1 each, functional-unit completion.
REQ-012 SHALL have cmp_tag0..2 (TAG_W), cmp_data0..2 (DATA_W), cmp_mispred0..2 (1), cmp_target0..2 (DATA_W), inputs, completion payload.
REQ-013 SHALL have wen0..2 (1), waddr0..2 (3), wdata0..2 (DATA_W), wrob0..2 (TAG_W), outputs, registered retire writes to register file.
REQ-014 SHALL have flush_out (1) and redirect_pc (DATA_W), outputs, registered mispredict recovery.
REQ-015 SHALL have count, output, TAG_W+1, occupied entries (0..64).

Function
REQ-016 Entry SHALL hold valid, done, wreg, waddr, data, mispred, target.
REQ-017 Allocation SHALL occur only when alloc_ready=1; alloc_cnt>0 with alloc_ready=0 SHALL be ignored entirely (no partial allocation).
REQ-018 Allocated entries SHALL start done=0; tail advances by alloc_cnt with wrap mod 64.
REQ-019 Completion SHALL set done, data, mispred, target of the tagged entry; completions to invalid entries SHALL be ignored.
REQ-020 Retire SHALL examine head, head+1, head+2 using done state registered before this edge; retire the longest in-order prefix (0..3) of valid done entries.
REQ-021 Entry completed at edge N SHALL be earliest retired at edge N+1; its wen appears after edge N+1.
REQ-022 Retire slot k SHALL drive wen_k=wreg, waddr_k, wdata_k, wrob_k=tag, registered; non-retiring slots drive wen_k=0.
REQ-023 Retiring entry with mispred=1 SHALL be last retired that cycle; next cycle flush_out=1 and redirect_pc=target for exactly one cycle; all entries SHALL be invalidated, head=tail=count=0.
REQ-024 Simultaneous alloc and retire SHALL be legal; count = count + alloc - retired.
REQ-025 Full (count=64): alloc_ready=0, retire and completion continue; empty: retire outputs all zero.
REQ-026 flush=1 SHALL take priority over alloc, completion, retire: next cycle all entries invalid, head=tail=count=0, wen0..2=0, flush_out=0.
REQ-027 Pointer wrap from 63 to 0 SHALL be seamless for alloc, retire and forwarding.

Reset
REQ-028 rst=1 SHALL immediately clear head, tail, count, all valid/done bits, wen0..2, waddr/wdata/wrob, flush_out, redirect_pc to 0.
REQ-029 rst asserted mid-operation SHALL discard all in-flight entries; first allocation after release gets tag 0.

Configuration
REQ-030 With ROB_FWD_EN defined: add inputs rd_tag0..7 (TAG_W), outputs rd_hit0..7 (1), rd_data0..7 (DATA_W), combinational; rd_hit = entry valid and done, rd_data = entry data.
REQ-031 Without ROB_FWD_EN: these ports SHALL not exist; no forwarding logic.

Verification
REQ-032 Reset, alloc_cnt=4 -> alloc_tag0..3 = 0,1,2,3; count=4 next cycle.
REQ-033 Complete tags 1 then 0 (data 0x11, 0x22) with wreg=1, waddr 3,5 -> one cycle after tag 0 completes, wen0/1=1, wrob 0/1, wdata 0x22/0x11.
REQ-034 Fill to 64, alloc_cnt=4 -> ignored, count stays 64; retire 3 -> alloc_ready=0 until count<=60.
REQ-035 Tags 0..2 done, tag 1 mispred target 0x0040 -> retire 0,1 only; flush_out=1, redirect_pc=0x0040 next cycle; count=0.
REQ-036 Head at 62, alloc 4 -> tags 62,63,0,1; retire wraps in order.
REQ-037 flush=1 with alloc_cnt=2 and cmp_valid0=1 same cycle -> count=0, wen0..2=0 next cycle.

Source files
------------

// File: rtl/rename_rob.sv
// rename_rob: 64-entry reorder buffer, 4-wide alloc, 3 completion ports, 3-wide in-order retire.
// Optional ROB_FWD_EN macro adds 8 combinational operand-forwarding read ports.
module rename_rob #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [2:0]        alloc_cnt,
  input  logic              alloc_wreg0, alloc_wreg1, alloc_wreg2, alloc_wreg3,
  input  logic [2:0]        alloc_waddr0, alloc_waddr1, alloc_waddr2, alloc_waddr3,
  output logic [TAG_W-1:0]  alloc_tag0, alloc_tag1, alloc_tag2, alloc_tag3,
  output logic              alloc_ready,
  input  logic              cmp_valid0, cmp_valid1, cmp_valid2,
  input  logic [TAG_W-1:0]  cmp_tag0, cmp_tag1, cmp_tag2,
  input  logic [DATA_W-1:0] cmp_data0, cmp_data1, cmp_data2,
  input  logic              cmp_mispred0, cmp_mispred1, cmp_mispred2,
  input  logic [DATA_W-1:0] cmp_target0, cmp_target1, cmp_target2,
  output logic              wen0, wen1, wen2,
  output logic [2:0]        waddr0, waddr1, waddr2,
  output logic [DATA_W-1:0] wdata0, wdata1, wdata2,
  output logic [TAG_W-1:0]  wrob0, wrob1, wrob2,
  output logic              flush_out,
  output logic [DATA_W-1:0] redirect_pc,
`ifdef ROB_FWD_EN
  input  logic [TAG_W-1:0]  rd_tag0, rd_tag1, rd_tag2, rd_tag3, rd_tag4, rd_tag5, rd_tag6, rd_tag7,
  output logic              rd_hit0, rd_hit1, rd_hit2, rd_hit3, rd_hit4, rd_hit5, rd_hit6, rd_hit7,
  output logic [DATA_W-1:0] rd_data0, rd_data1, rd_data2, rd_data3, rd_data4, rd_data5, rd_data6, rd_data7,
`endif
  output logic [TAG_W:0]    count
);
  localparam int DEPTH = 1 << TAG_W;
  logic [DEPTH-1:0]  valid_q, done_q;
  logic              wreg_q [DEPTH];
  logic [2:0]        wad_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              mis_q [DEPTH];
  logic [DATA_W-1:0] tgt_q [DEPTH];
  logic [TAG_W-1:0]  head_q, tail_q;
  logic [TAG_W:0]    count_q, alloc_n, ret_n;
  logic [2:0]               o_wen_q;
  logic [2:0][2:0]          o_wa_q;
  logic [2:0][DATA_W-1:0]   o_wd_q;
  logic [2:0][TAG_W-1:0]    o_wr_q;
  logic                     fo_q;
  logic [DATA_W-1:0]        pc_q;
  logic [3:0]               a_wreg, alloc_en;
  logic [3:0][2:0]          a_waddr;
  logic [2:0]               c_v, c_m, c_hit, rv, ret_ok;
  logic [2:0][TAG_W-1:0]    c_tag;
  logic [2:0][DATA_W-1:0]   c_data, c_tgt;
  logic [TAG_W-1:0]         h [3];
  logic                     do_alloc, mis;
  logic [DATA_W-1:0]        mis_tgt;
  assign a_wreg  = {alloc_wreg3, alloc_wreg2, alloc_wreg1, alloc_wreg0};
  assign a_waddr = {alloc_waddr3, alloc_waddr2, alloc_waddr1, alloc_waddr0};
  assign c_v     = {cmp_valid2, cmp_valid1, cmp_valid0};
  assign c_m     = {cmp_mispred2, cmp_mispred1, cmp_mispred0};
  assign c_tag   = {cmp_tag2, cmp_tag1, cmp_tag0};
  assign c_data  = {cmp_data2, cmp_data1, cmp_data0};
  assign c_tgt   = {cmp_target2, cmp_target1, cmp_target0};
  assign alloc_tag0  = tail_q;
  assign alloc_tag1  = tail_q + TAG_W'(1);
  assign alloc_tag2  = tail_q + TAG_W'(2);
  assign alloc_tag3  = tail_q + TAG_W'(3);
  assign alloc_ready = count_q <= (TAG_W+1)'(DEPTH - 4);
  assign do_alloc    = alloc_ready && alloc_cnt != 3'd0 && !flush;
  assign alloc_n     = do_alloc ? (TAG_W+1)'(alloc_cnt) : '0;
  // a mispredicting entry ends the retire group, so it is always the last set bit of rv
  always_comb begin
    for (int k = 0; k < 3; k++) h[k] = head_q + TAG_W'(k);
    for (int i = 0; i < 4; i++) alloc_en[i] = do_alloc && 3'(i) < alloc_cnt;
    for (int j = 0; j < 3; j++) c_hit[j] = c_v[j] && valid_q[c_tag[j]];
    rv[0]   = valid_q[h[0]] && done_q[h[0]];
    rv[1]   = rv[0] && !mis_q[h[0]] && valid_q[h[1]] && done_q[h[1]];
    rv[2]   = rv[1] && !mis_q[h[1]] && valid_q[h[2]] && done_q[h[2]];
    ret_ok  = rv & {3{!flush}};
    ret_n   = (TAG_W+1)'(rv[0]) + (TAG_W+1)'(rv[1]) + (TAG_W+1)'(rv[2]);
    mis     = |(ret_ok & ~{1'b0, rv[2:1]} & {mis_q[h[2]], mis_q[h[1]], mis_q[h[0]]});
    mis_tgt = rv[2] ? tgt_q[h[2]] : rv[1] ? tgt_q[h[1]] : tgt_q[h[0]];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (alloc_en[i]) begin
        wreg_q[tail_q + TAG_W'(i)] <= a_wreg[i];
        wad_q[tail_q + TAG_W'(i)]  <= a_waddr[i];
      end
    for (int j = 0; j < 3; j++)
      if (c_hit[j]) begin
        data_q[c_tag[j]] <= c_data[j];
        mis_q[c_tag[j]]  <= c_m[j];
        tgt_q[c_tag[j]]  <= c_tgt[j];
      end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      o_wen_q <= '0;
      o_wa_q  <= '0;
      o_wd_q  <= '0;
      o_wr_q  <= '0;
      fo_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        o_wen_q[k] <= ret_ok[k] && wreg_q[h[k]];
        o_wa_q[k]  <= ret_ok[k] ? wad_q[h[k]] : '0;
        o_wd_q[k]  <= ret_ok[k] ? data_q[h[k]] : '0;
        o_wr_q[k]  <= ret_ok[k] ? h[k] : '0;
      end
      fo_q <= mis;
      pc_q <= mis ? mis_tgt : '0;
      if (flush || mis) begin
        valid_q <= '0;
        done_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        for (int k = 0; k < 3; k++) if (rv[k]) valid_q[h[k]] <= 1'b0;
        for (int i = 0; i < 4; i++)
          if (alloc_en[i]) begin
            valid_q[tail_q + TAG_W'(i)] <= 1'b1;
            done_q[tail_q + TAG_W'(i)]  <= 1'b0;
          end
        for (int j = 0; j < 3; j++) if (c_hit[j]) done_q[c_tag[j]] <= 1'b1;
        head_q  <= head_q + TAG_W'(ret_n);
        tail_q  <= tail_q + TAG_W'(alloc_n);
        count_q <= count_q + alloc_n - ret_n;
      end
    end
  end
  assign {wen2, wen1, wen0}       = o_wen_q;
  assign {waddr2, waddr1, waddr0} = o_wa_q;
  assign {wdata2, wdata1, wdata0} = o_wd_q;
  assign {wrob2, wrob1, wrob0}    = o_wr_q;
  assign flush_out   = fo_q;
  assign redirect_pc = pc_q;
  assign count       = count_q;
`ifdef ROB_FWD_EN
  logic [7:0][TAG_W-1:0]  rt;
  logic [7:0]             rh;
  logic [7:0][DATA_W-1:0] rdat;
  assign rt = {rd_tag7, rd_tag6, rd_tag5, rd_tag4, rd_tag3, rd_tag2, rd_tag1, rd_tag0};
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      rh[k]   = valid_q[rt[k]] && done_q[rt[k]];
      rdat[k] = data_q[rt[k]];
    end
  end
  assign {rd_hit7, rd_hit6, rd_hit5, rd_hit4, rd_hit3, rd_hit2, rd_hit1, rd_hit0} = rh;
  assign {rd_data7, rd_data6, rd_data5, rd_data4, rd_data3, rd_data2, rd_data1, rd_data0} = rdat;
`endif
endmodule

// File: tb/tb_rename_rob.sv
// tb_rename_rob: directed stimulus with a scoreboard queue of expected retire/redirect records.
module tb_rename_rob;
  localparam int DW = 16;
  localparam int TW = 6;
  logic clk = 1'b0;
  logic rst, flush;
  logic [2:0] alloc_cnt;
  logic alloc_wreg0, alloc_wreg1, alloc_wreg2, alloc_wreg3;
  logic [2:0] alloc_waddr0, alloc_waddr1, alloc_waddr2, alloc_waddr3;
  logic [TW-1:0] alloc_tag0, alloc_tag1, alloc_tag2, alloc_tag3;
  logic alloc_ready;
  logic cmp_valid0, cmp_valid1, cmp_valid2;
  logic [TW-1:0] cmp_tag0, cmp_tag1, cmp_tag2;
  logic [DW-1:0] cmp_data0, cmp_data1, cmp_data2;
  logic cmp_mispred0, cmp_mispred1, cmp_mispred2;
  logic [DW-1:0] cmp_target0, cmp_target1, cmp_target2;
  logic wen0, wen1, wen2;
  logic [2:0] waddr0, waddr1, waddr2;
  logic [DW-1:0] wdata0, wdata1, wdata2;
  logic [TW-1:0] wrob0, wrob1, wrob2;
  logic flush_out;
  logic [DW-1:0] redirect_pc;
  logic [TW:0] count;
`ifdef ROB_FWD_EN
  logic [TW-1:0] rd_tag [8];
  logic rd_hit [8];
  logic [DW-1:0] rd_data [8];
  initial for (int i = 0; i < 8; i++) rd_tag[i] = '0;
`endif

  rename_rob #(.DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_cnt(alloc_cnt),
    .alloc_wreg0(alloc_wreg0), .alloc_wreg1(alloc_wreg1), .alloc_wreg2(alloc_wreg2), .alloc_wreg3(alloc_wreg3),
    .alloc_waddr0(alloc_waddr0), .alloc_waddr1(alloc_waddr1), .alloc_waddr2(alloc_waddr2), .alloc_waddr3(alloc_waddr3),
    .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2), .alloc_tag3(alloc_tag3),
    .alloc_ready(alloc_ready),
    .cmp_valid0(cmp_valid0), .cmp_valid1(cmp_valid1), .cmp_valid2(cmp_valid2),
    .cmp_tag0(cmp_tag0), .cmp_tag1(cmp_tag1), .cmp_tag2(cmp_tag2),
    .cmp_data0(cmp_data0), .cmp_data1(cmp_data1), .cmp_data2(cmp_data2),
    .cmp_mispred0(cmp_mispred0), .cmp_mispred1(cmp_mispred1), .cmp_mispred2(cmp_mispred2),
    .cmp_target0(cmp_target0), .cmp_target1(cmp_target1), .cmp_target2(cmp_target2),
    .wen0(wen0), .wen1(wen1), .wen2(wen2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .wrob0(wrob0), .wrob1(wrob1), .wrob2(wrob2),
    .flush_out(flush_out), .redirect_pc(redirect_pc),
`ifdef ROB_FWD_EN
    .rd_tag0(rd_tag[0]), .rd_tag1(rd_tag[1]), .rd_tag2(rd_tag[2]), .rd_tag3(rd_tag[3]),
    .rd_tag4(rd_tag[4]), .rd_tag5(rd_tag[5]), .rd_tag6(rd_tag[6]), .rd_tag7(rd_tag[7]),
    .rd_hit0(rd_hit[0]), .rd_hit1(rd_hit[1]), .rd_hit2(rd_hit[2]), .rd_hit3(rd_hit[3]),
    .rd_hit4(rd_hit[4]), .rd_hit5(rd_hit[5]), .rd_hit6(rd_hit[6]), .rd_hit7(rd_hit[7]),
    .rd_data0(rd_data[0]), .rd_data1(rd_data[1]), .rd_data2(rd_data[2]), .rd_data3(rd_data[3]),
    .rd_data4(rd_data[4]), .rd_data5(rd_data[5]), .rd_data6(rd_data[6]), .rd_data7(rd_data[7]),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]         wen;
    logic [2:0][2:0]    wa;
    logic [2:0][DW-1:0] wd;
    logic [2:0][TW-1:0] wr;
    logic               fo;
    logic [DW-1:0]      pc;
  } rec_t;

  rec_t q[$];
  rec_t act, exp_r;
  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] m_wa [64];
  logic [DW-1:0] m_data [64];
  logic [TW-1:0] m_tail;

  assign act = {{wen2, wen1, wen0}, {waddr2, waddr1, waddr0}, {wdata2, wdata1, wdata0},
                {wrob2, wrob1, wrob0}, flush_out, redirect_pc};

  always @(negedge clk) begin
    if (!rst && (act.wen != 3'b000 || act.fo)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL retire_unexpected: got %h expected no retire", act);
      end else begin
        exp_r = q.pop_front();
        if (act !== exp_r) begin
          n_fail++;
          $display("FAIL retire_record: got %h expected %h", act, exp_r);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic idle();
    flush = 1'b0;
    alloc_cnt = '0;
    {alloc_wreg0, alloc_wreg1, alloc_wreg2, alloc_wreg3} = '0;
    {alloc_waddr0, alloc_waddr1, alloc_waddr2, alloc_waddr3} = '0;
    {cmp_valid0, cmp_valid1, cmp_valid2} = '0;
    {cmp_tag0, cmp_tag1, cmp_tag2} = '0;
    {cmp_data0, cmp_data1, cmp_data2} = '0;
    {cmp_mispred0, cmp_mispred1, cmp_mispred2} = '0;
    {cmp_target0, cmp_target1, cmp_target2} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_alloc(input int n, input bit take = 1'b1, input logic [2:0] w0 = 3'd1,
                           input logic [2:0] w1 = 3'd2, input logic [2:0] w2 = 3'd3, input logic [2:0] w3 = 3'd4);
    logic [2:0] w [4];
    w = '{w0, w1, w2, w3};
    alloc_cnt = 3'(n);
    {alloc_wreg3, alloc_wreg2, alloc_wreg1, alloc_wreg0} = 4'hF;
    {alloc_waddr3, alloc_waddr2, alloc_waddr1, alloc_waddr0} = {w3, w2, w1, w0};
    if (take) begin
      for (int i = 0; i < n; i++) m_wa[m_tail + TW'(i)] = w[i];
      m_tail = m_tail + TW'(n);
    end
  endtask

  task automatic set_cmp(input int j, input int tag, input logic [DW-1:0] d,
                         input bit mis = 1'b0, input logic [DW-1:0] tgt = '0);
    m_data[tag % 64] = d;
    case (j)
      0: begin cmp_valid0 = 1'b1; cmp_tag0 = TW'(tag); cmp_data0 = d; cmp_mispred0 = mis; cmp_target0 = tgt; end
      1: begin cmp_valid1 = 1'b1; cmp_tag1 = TW'(tag); cmp_data1 = d; cmp_mispred1 = mis; cmp_target1 = tgt; end
      default: begin cmp_valid2 = 1'b1; cmp_tag2 = TW'(tag); cmp_data2 = d; cmp_mispred2 = mis; cmp_target2 = tgt; end
    endcase
  endtask

  function automatic rec_t mk(input int n, input int t0, input bit fo = 1'b0, input logic [DW-1:0] pc = '0);
    rec_t r;
    r = '0;
    for (int k = 0; k < n; k++) begin
      r.wen[k] = 1'b1;
      r.wa[k]  = m_wa[(t0 + k) % 64];
      r.wd[k]  = m_data[(t0 + k) % 64];
      r.wr[k]  = TW'((t0 + k) % 64);
    end
    r.fo = fo;
    r.pc = pc;
    return r;
  endfunction

  initial begin
    idle();
    m_tail = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(count), 0);
    chk("reset_ready", 32'(alloc_ready), 1);
    chk("reset_tag0", 32'(alloc_tag0), 0);
    chk("reset_wen", 32'({wen2, wen1, wen0}), 0);
    chk("reset_flush_out", 32'(flush_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // first allocation after reset
    set_alloc(4, 1'b1, 3'd3, 3'd5, 3'd6, 3'd7);
    #1;
    chk("alloc_tags_0123", 32'({alloc_tag3, alloc_tag2, alloc_tag1, alloc_tag0}), 32'({6'd3, 6'd2, 6'd1, 6'd0}));
    tick();
    chk("count_after_alloc4", 32'(count), 4);
    // out-of-order completion, in-order retire one edge after the head completes
    set_cmp(0, 1, 16'h0011);
    tick();
    set_cmp(0, 0, 16'h0022);
    q.push_back(mk(2, 0));
    tick();
    chk("count_before_retire", 32'(count), 4);
    tick();
    chk("count_after_retire2", 32'(count), 2);
    set_cmp(0, 2, 16'h0033);
    set_cmp(1, 3, 16'h0044);
    q.push_back(mk(2, 2));
    tick();
    tick();
    chk("count_drained", 32'(count), 0);
    // asynchronous reset mid-operation
    set_alloc(4);
    tick();
    chk("count_before_rst", 32'(count), 4);
    set_cmp(0, 4, 16'h0055);
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_tag0", 32'(alloc_tag0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_tail = '0;
    // mispredict on tag 1 stops retire and redirects
    set_alloc(4);
    tick();
    set_cmp(0, 0, 16'h0100);
    set_cmp(1, 1, 16'h0101, 1'b1, 16'h0040);
    set_cmp(2, 2, 16'h0102);
    q.push_back(mk(2, 0, 1'b1, 16'h0040));
    tick();
    tick();
    chk("mispred_count", 32'(count), 0);
    chk("mispred_tag0", 32'(alloc_tag0), 0);
    tick();
    chk("flush_out_one_cycle", 32'(flush_out), 0);
    m_tail = '0;
    // fill to full, ignored allocation, retire under full
    for (int g = 0; g < 16; g++) begin
      set_alloc(4);
      tick();
    end
    chk("full_count", 32'(count), 64);
    chk("full_ready", 32'(alloc_ready), 0);
    set_alloc(4, 1'b0);
    tick();
    chk("full_alloc_ignored", 32'(count), 64);
    chk("full_tail_unmoved", 32'(alloc_tag0), 0);
    set_cmp(0, 0, 16'h0200);
    set_cmp(1, 1, 16'h0201);
    set_cmp(2, 2, 16'h0202);
    q.push_back(mk(3, 0));
    tick();
    tick();
    chk("count_61", 32'(count), 61);
    chk("ready_at_61", 32'(alloc_ready), 0);
    set_cmp(0, 3, 16'h0203);
    q.push_back(mk(1, 3));
    tick();
    tick();
    chk("count_60", 32'(count), 60);
    chk("ready_at_60", 32'(alloc_ready), 1);
    // external flush beats a pending retire, alloc and completion
    set_cmp(0, 4, 16'h0204);
    tick();
    flush = 1'b1;
    set_alloc(2, 1'b0);
    set_cmp(0, 5, 16'h0205);
    tick();
    chk("flush_count", 32'(count), 0);
    chk("flush_wen", 32'({wen2, wen1, wen0}), 0);
    chk("flush_flush_out", 32'(flush_out), 0);
    chk("flush_tag0", 32'(alloc_tag0), 0);
    m_tail = '0;
    // walk head to 62, then allocate across the wrap
    for (int g = 0; g < 15; g++) begin
      set_alloc(4);
      tick();
    end
    set_alloc(2);
    tick();
    for (int g = 0; g < 62; g += 3) begin
      int n;
      n = (62 - g) < 3 ? 62 - g : 3;
      for (int k = 0; k < n; k++) set_cmp(k, g + k, 16'h0300 + 16'(g + k));
      q.push_back(mk(n, g));
      tick();
    end
    tick();
    chk("head62_count", 32'(count), 0);
    set_alloc(4);
    #1;
    chk("wrap_tags", 32'({alloc_tag3, alloc_tag2, alloc_tag1, alloc_tag0}), 32'({6'd1, 6'd0, 6'd63, 6'd62}));
    tick();
    chk("wrap_count", 32'(count), 4);
    set_cmp(0, 63, 16'h0463);
    set_cmp(1, 0, 16'h0400);
    set_cmp(2, 1, 16'h0401);
    tick();
    set_cmp(0, 62, 16'h0462);
    q.push_back(mk(3, 62));
    q.push_back(mk(1, 1));
    tick();
    tick();
    tick();
    chk("wrap_drained", 32'(count), 0);
    tick();
    tick();
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
